// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetcher: keeps a small circular buffer of words at
// head_addr, head_addr+STEP, ... and restarts from any non-sequential fetch.
module inst_prefetch_buffer #(
    parameter int DEPTH = 4,
    parameter int STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_valid,
    output logic [31:0] fetch_data,
    output logic        fetch_ready,
    output logic [31:0] mem_addr,
    output logic        mem_valid,
    input  logic [31:0] mem_data,
    input  logic        mem_ready
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
    localparam logic [31:0]      STEP_W = 32'(STEP);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        STALE
    } req_state_e;

    req_state_e       state_q, state_d;
    logic [31:0]      buf_q [DEPTH];
    logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      head_addr_q, head_addr_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      next_seq;
    logic [PTR_W-1:0] fill_ptr;
    logic             hit, redirect, fill;

    always_comb begin
        hit      = fetch_valid && (count_q != '0) && (fetch_addr == head_addr_q);
        redirect = fetch_valid && (fetch_addr != head_addr_q);
        fill     = (state_q == REQ) && mem_ready && !redirect;
        // Fill slot uses the pre-pop pointer so a simultaneous hit cannot shift it.
        fill_ptr = head_ptr_q + count_q[PTR_W-1:0];

        head_ptr_d = hit ? head_ptr_q + PTR_W'(1) : head_ptr_q;

        if (redirect) begin
            count_d     = '0;
            head_addr_d = fetch_addr;
        end else begin
            count_d     = count_q + CNT_W'(fill) - CNT_W'(hit);
            head_addr_d = hit ? head_addr_q + STEP_W : head_addr_q;
        end

        next_seq = head_addr_d + 32'(count_d) * STEP_W;
    end

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        unique case (state_q)
            IDLE: begin
                if (count_d < FULL) begin
                    state_d    = REQ;
                    mem_addr_d = next_seq;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    // A redirect leaves count_d at zero, so this reissues at fetch_addr.
                    if (count_d < FULL) begin
                        state_d    = REQ;
                        mem_addr_d = next_seq;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (redirect) begin
                    state_d = STALE;
                end
            end
            STALE: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            head_ptr_q  <= '0;
            count_q     <= '0;
            head_addr_q <= '0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            head_ptr_q  <= head_ptr_d;
            count_q     <= count_d;
            head_addr_q <= head_addr_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            buf_q[fill_ptr] <= mem_data;
        end
    end

    assign fetch_ready = hit;
    assign fetch_data  = buf_q[head_ptr_q];
    assign mem_valid   = (state_q != IDLE);
    assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed bench for inst_prefetch_buffer: fill, streaming, redirects,
// address wrap and asynchronous reset.
module tb_inst_prefetch_buffer;
    logic        clk;
    logic        reset;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        mem_ready;

    logic        auto_mem;
    logic        auto_ready, man_ready;
    logic [31:0] auto_data, man_data;
    int          lat;
    int          wcnt;
    int          n_checks;
    int          n_errors;
    logic [31:0] log_q[$];

    inst_prefetch_buffer #(.DEPTH(4), .STEP(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_addr (fetch_addr),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .fetch_ready(fetch_ready),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ready = auto_mem ? auto_ready : man_ready;
    assign mem_data  = auto_mem ? auto_data  : man_data;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    // Memory model: answers after lat cycles of a held request.
    always @(negedge clk) begin
        if (!reset || !mem_valid) begin
            wcnt = 0;
            auto_ready = 1'b0;
        end else begin
            wcnt = wcnt + 1;
            if (wcnt >= lat) begin
                auto_ready = 1'b1;
                auto_data  = memval(mem_addr);
                wcnt = 0;
            end else begin
                auto_ready = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (reset && mem_valid && mem_ready) log_q.push_back(mem_addr);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        repeat (2) cyc();
        log_q.delete();
        reset = 1'b1;
    endtask

    task automatic fetch_word(input logic [31:0] a);
        bit got;
        got = 1'b0;
        fetch_addr = a;
        for (int t = 0; t < 40 && !got; t++) begin
            #1;
            if (fetch_ready) begin
                got = 1'b1;
                check_val("fetch_data", fetch_data, memval(a));
            end
            cyc();
        end
        check_val("fetch_hit", {31'b0, got}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_errors = 0;
        reset = 1'b0; fetch_valid = 1'b1; fetch_addr = 32'h0;
        man_ready = 1'b0; man_data = 32'h0; auto_mem = 1'b1; lat = 1;
        repeat (2) cyc();
        check_val("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        check_val("rst_fetch_ready", {31'b0, fetch_ready}, 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'h0);

        // Fill from reset with single-cycle memory
        fetch_valid = 1'b0;
        reset_dut();
        for (int t = 0; t < 20 && log_q.size() < 4; t++) cyc();
        repeat (2) cyc();
        check_val("fill_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_val("fill_addr", log_q[i], 32'(i * 4));
        check_val("full_idle", {31'b0, mem_valid}, 32'd0);
        fetch_addr = 32'h0; fetch_valid = 1'b1;
        #1;
        check_val("full_hit", {31'b0, fetch_ready}, 32'd1);
        check_val("full_hit_data", fetch_data, memval(32'h0));
        cyc();
        fetch_valid = 1'b0;
        check_val("reissue_valid", {31'b0, mem_valid}, 32'd1);
        check_val("reissue_addr", mem_addr, 32'h10);

        // Sequential stream, 3-cycle memory
        lat = 3;
        reset_dut();
        fetch_valid = 1'b1;
        for (int k = 0; k < 16; k++) fetch_word(32'(k * 4));
        fetch_valid = 1'b0;

        // Redirect while the 0x8 request is outstanding
        auto_mem = 1'b0; man_ready = 1'b0;
        reset_dut();
        cyc();
        check_val("first_req", mem_addr, 32'h0);
        man_ready = 1'b1; man_data = memval(32'h0);
        cyc();
        man_data = memval(32'h4);
        cyc();
        man_ready = 1'b0;
        fetch_valid = 1'b1; fetch_addr = 32'h100;
        #1;
        check_val("redir_no_hit", {31'b0, fetch_ready}, 32'd0);
        cyc();
        check_val("stale_valid", {31'b0, mem_valid}, 32'd1);
        check_val("stale_addr", mem_addr, 32'h8);
        cyc();
        check_val("stale_hold", mem_addr, 32'h8);
        man_ready = 1'b1; man_data = 32'hBAD0_0008;
        cyc();
        man_ready = 1'b0;
        check_val("stale_drop", {31'b0, mem_valid}, 32'd0);
        #1;
        check_val("stale_no_hit", {31'b0, fetch_ready}, 32'd0);
        cyc();
        check_val("redir_req_valid", {31'b0, mem_valid}, 32'd1);
        check_val("redir_req_addr", mem_addr, 32'h100);
        check_val("redir_wait", {31'b0, fetch_ready}, 32'd0);
        man_ready = 1'b1; man_data = memval(32'h100);
        cyc();
        man_ready = 1'b0;
        #1;
        check_val("redir_hit", {31'b0, fetch_ready}, 32'd1);
        check_val("redir_data", fetch_data, memval(32'h100));

        // Redirect coinciding with mem_ready in REQ
        cyc();
        check_val("pop_next_req", mem_addr, 32'h104);
        man_ready = 1'b1; man_data = memval(32'h104);
        fetch_addr = 32'h200;
        #1;
        check_val("same_cyc_no_hit", {31'b0, fetch_ready}, 32'd0);
        cyc();
        man_ready = 1'b0;
        check_val("same_cyc_valid", {31'b0, mem_valid}, 32'd1);
        check_val("same_cyc_addr", mem_addr, 32'h200);
        #1;
        check_val("same_cyc_empty", {31'b0, fetch_ready}, 32'd0);
        man_ready = 1'b1; man_data = memval(32'h200);
        cyc();
        man_ready = 1'b0;
        #1;
        check_val("same_cyc_hit", {31'b0, fetch_ready}, 32'd1);
        check_val("same_cyc_data", fetch_data, memval(32'h200));
        fetch_valid = 1'b0;

        // 32-bit address wrap
        auto_mem = 1'b1; lat = 1;
        fetch_valid = 1'b1; fetch_addr = 32'hFFFF_FFF8;
        reset_dut();
        fetch_word(32'hFFFF_FFF8);
        fetch_word(32'hFFFF_FFFC);
        fetch_word(32'h0000_0000);
        fetch_word(32'h0000_0004);
        check_val("wrap_req0", log_q[0], 32'hFFFF_FFF8);
        check_val("wrap_req1", log_q[1], 32'hFFFF_FFFC);
        check_val("wrap_req2", log_q[2], 32'h0000_0000);
        check_val("wrap_req3", log_q[3], 32'h0000_0004);
        fetch_valid = 1'b0;

        // Asynchronous reset between clock edges
        auto_mem = 1'b0; man_ready = 1'b0;
        reset_dut();
        cyc();
        man_ready = 1'b1; man_data = memval(32'h0);
        cyc();
        man_ready = 1'b0;
        fetch_valid = 1'b1; fetch_addr = 32'h0;
        #1;
        check_val("pre_rst_hit", {31'b0, fetch_ready}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_mem_valid", {31'b0, mem_valid}, 32'd0);
        check_val("arst_fetch_ready", {31'b0, fetch_ready}, 32'd0);
        check_val("arst_mem_addr", mem_addr, 32'h0);
        cyc();
        cyc();
        reset = 1'b1;
        #1;
        check_val("post_rst_idle", {31'b0, mem_valid}, 32'd0);
        check_val("post_rst_empty", {31'b0, fetch_ready}, 32'd0);
        cyc();
        check_val("post_rst_valid", {31'b0, mem_valid}, 32'd1);
        check_val("post_rst_addr", mem_addr, 32'h0);
        check_val("post_rst_wait", {31'b0, fetch_ready}, 32'd0);
        fetch_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/inst_prefetch_buffer.md
Name: inst_prefetch_buffer

Overview:
- Sits directly upstream of the fetch stage, between the fetcher's instruction-memory port and the real instruction memory.
- Speculatively prefetches sequential words (PC, PC+4, ...) into a small circular buffer, so sequential fetches hit without memory latency.
- A fetch to any address other than the buffer head is a redirect: the buffer flushes and restarts prefetch from that address.

Parameters:
- DEPTH, 4: buffer entries; power of two, at least 2.
- STEP, 4: byte increment between consecutive prefetched words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- fetch_addr  in  32  address requested by the fetcher.
- fetch_valid  in  1  fetcher request; held until fetch_ready.
- fetch_data  out  32  instruction word; valid when fetch_ready=1.
- fetch_ready  out  1  hit; pops one entry this cycle.
- mem_addr  out  32  registered memory request address.
- mem_valid  out  1  memory request pending.
- mem_data  in  32  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory returns mem_data for mem_addr this cycle.

Behaviour:
- Memory protocol:
  - At most one outstanding request.
  - While mem_valid=1, mem_addr is held stable until a cycle with mem_ready=1.
  - mem_ready ignored when mem_valid=0.
- State:
  - buf[DEPTH], head_ptr, count (0..DEPTH), head_addr (address of buf[head_ptr]), req FSM {IDLE, REQ, STALE}.
- Reset (reset=0, async):
  - count=0, head_ptr=0, head_addr=0, FSM=IDLE, mem_addr=0.
  - fetch_ready=0 and mem_valid=0 while in reset.
  - Any outstanding memory request is abandoned; memory must tolerate mem_valid dropping.
- Hit (combinational):
  - fetch_ready = fetch_valid && count>0 && fetch_addr==head_addr.
  - fetch_data = buf[head_ptr].
  - On hit: head_ptr+1 mod DEPTH, head_addr+=STEP, count-1.
- Wait:
  - fetch_valid && count==0 && fetch_addr==head_addr → no action; fetch_ready=0 until the word arrives.
  - Minimum latency after a miss: memory latency + 1 cycle. No memory-to-fetch bypass.
- Redirect:
  - Trigger: fetch_valid && fetch_addr!=head_addr (full 32-bit compare, any count).
  - Effect: count=0 and head_addr=fetch_addr; head_ptr is unchanged.
  - FSM: REQ→STALE; STALE stays STALE; IDLE→REQ is taken next cycle via the normal issue rule.
- mem_valid = (FSM != IDLE).
- FSM transitions:
  - IDLE → REQ when count<DEPTH. Sets mem_addr = head_addr + count*STEP, computed on post-update values.
  - REQ, mem_ready=1, no redirect:
    - Write buf[(head_ptr+count) mod DEPTH] = mem_data; count+1.
    - If the new count<DEPTH: stay REQ with mem_addr = next sequential address. Else go IDLE.
  - REQ, mem_ready=1, with redirect in the same cycle: discard the data; go REQ at fetch_addr next cycle.
  - STALE, mem_ready=1: discard the data; go IDLE (reissues from the new head the following cycle).
- Simultaneous hit and fill: count unchanged.
  - Fill slot is computed from the pre-pop head_ptr+count.
  - Next mem_addr uses the post-update head_addr+count*STEP.
- Full (count==DEPTH): no new request issued. A pop re-enables issue next cycle.
- Addresses:
  - Arithmetic is mod 2^32; 0xFFFFFFFC+4 wraps to 0.
  - Misaligned addresses are not special-cased.
- Invariant: count never exceeds DEPTH and never underflows.

Test Plan:
- Reset, memory with 1-cycle ready, buffer fills:
  - mem_addr sequence 0x0, 0x4, 0x8, 0xC, then mem_valid=0.
  - Fetcher then requests 0x0: fetch_ready=1 same cycle, data=mem[0x0]; next request issued at 0x10.
- Sequential fetch stream 0x0..0x3C with 3-cycle memory latency:
  - Each fetch_data matches mem[addr].
  - count stays within 0..4; no stale word is ever delivered.
- Redirect to 0x100 while the request at 0x8 is in flight:
  - mem_addr holds 0x8 until mem_ready, and that data is discarded.
  - Next request is 0x100; fetch_ready is first asserted with data=mem[0x100].
- Redirect in the same cycle as mem_ready in REQ:
  - Data not written, count=0.
  - Next mem_addr = the new fetch_addr.
- Wrap-around: redirect to 0xFFFFFFF8 → requests 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; fetches across the wrap hit.
- Async reset asserted mid-request (between clock edges):
  - mem_valid and fetch_ready drop immediately, count=0.
  - After release, the first request is at 0x0.
